chacha20_keystream_sched: RTL and testbench
===========================================

// Module: chacha20_keystream_sched
// PURPOSE
//  Sequencer that owns one chacha20_block core and feeds a keystream word stream.
//  Holds key/nonce/counter, issues one-block jobs (parallel_blocks=0), auto-increments counter,
//  prefetches into a 2-slot block buffer, and drains 32-bit words over valid/ready.
//  Sits between the cipher XOR datapath (consumer) and chacha20_block (core).
// PARAMETERS
//  TIMEOUT_CYCLES  255  core_done watchdog limit, counted from core_start; used only with CHACHA_SCHED_WDOG_EN
// PORTS
//  clk             in   1    clock; single clock domain
//  rst             in   1    asynchronous, active-high reset
//  cfg_load        in   1    1-cycle pulse: latch cfg_*, flush buffer, restart
//  cfg_key         in   256  key, passed unchanged to core_key
//  cfg_nonce       in   96   nonce, passed unchanged to core_nonce
//  cfg_counter     in   32   first block counter
//  core_start      out  1    1-cycle start pulse to core
//  core_key        out  256  registered key
//  core_nonce      out  96   registered nonce
//  core_counter    out  32   counter of job in flight
//  core_parallel   out  2    tied 2'b00
//  core_ks         in   512  core keystream_blocks[511:0]
//  core_done       in   1    core 1-cycle done pulse
//  ks_valid        out  1    ks_word valid
//  ks_ready        in   1    consumer accepts when valid&ready
//  ks_word         out  32   keystream word; word w of block = core_ks[32w+:32], w=0..15
//  ks_last         out  1    high with word 15 of a block
//  busy            out  1    core job in flight
//  exhausted       out  1    sticky: block with counter 32'hFFFFFFFF issued
//  err_timeout     out  1    sticky watchdog flag (0 when macro off)
// BEHAVIOUR
//  Reset: all outputs 0; cfg regs 0; buffer empty; FSM IDLE; configured=0.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE; DISCARD entered from WAIT on cfg_load.
//   IDLE: if configured & !exhausted & free slot -> ISSUE.
//   ISSUE: core_start=1 one cycle, core_counter=ctr, busy=1 -> WAIT.
//   WAIT: on core_done capture core_ks into tail slot, ctr<=ctr+1 (mod 2^32), busy=0 -> IDLE.
//    exhausted set when issued counter==32'hFFFFFFFF; no further issue until cfg_load.
//   DISCARD: in-flight result dropped; on core_done -> IDLE (then reissues with new cfg).
//  Latency: cfg_load at cycle N -> core_start at N+2 (no job in flight); core_done at M ->
//   ks_valid at M+1 if buffer was empty.
//  Drain: head slot words out 0..15; word index advances on valid&ready; ks_last on 15;
//   slot freed on word-15 handshake; next slot's word 0 presented next cycle (no bubble).
//  Prefetch: free slot frees issue; slot freed and core_done same cycle -> both honoured.
//  ks_word/ks_valid stable while valid&!ready (AXI-style; no retraction).
//  cfg_load: same-edge flush (ks_valid=0 next cycle), word index 0, exhausted/err_timeout
//   cleared, ctr<=cfg_counter, configured=1; if WAIT -> DISCARD; handshake in that cycle ignored.
//  cfg_load in ISSUE: start still pulses, FSM -> DISCARD.
//  Core_done outside WAIT/DISCARD ignored. Full (2 slots) -> IDLE stalls, no start.
// CONFIGURATION
//  CHACHA_SCHED_WDOG_EN defined: cycle counter from core_start; reaching TIMEOUT_CYCLES in
//   WAIT/DISCARD sets err_timeout, drops job, -> IDLE, no further issue until cfg_load.
//  Undefined: no counter logic, err_timeout tied 0, WAIT waits indefinitely.
// TESTING (stub core: done 6 cycles after start, word w = {ctr[23:0], w[7:0]})
//  cfg_counter=1, ks_ready=1 -> 32 words: 0x00000100..0x0000010F then 0x00000200..; ks_last on
//   each 16th.
//  ks_ready=0 after load -> exactly 2 starts (ctr 1,2), then none; ready=1 -> 3rd start at the
//   cycle after slot 0's word-15 handshake.
//  cfg_counter=32'hFFFFFFFE -> blocks FE,FF delivered, exhausted=1, no 3rd start; cfg_load
//   clears it.
//  cfg_load 3 cycles after start (ctr=5), new cfg_counter=0x40 -> old done dropped,
//   first word 0x00004000.
//  WDOG_EN, TIMEOUT_CYCLES=16, stub never done -> err_timeout=1 at start+16, busy=0, no restart.
//  rst asserted mid-WAIT and mid-drain -> all outputs 0 asynchronously; no start until cfg_load.

Source files
------------

// File: rtl/chacha20_keystream_sched_if.sv
// Keystream word stream from the scheduler (master) to the cipher XOR datapath (slave).
interface chacha20_keystream_sched_if;
   logic        ks_valid;
   logic        ks_ready;
   logic [31:0] ks_word;
   logic        ks_last;

   modport master (output ks_valid, output ks_word, output ks_last, input ks_ready);
   modport slave  (input ks_valid, input ks_word, input ks_last, output ks_ready);
endinterface

// File: rtl/chacha20_keystream_sched.sv
// ChaCha20 keystream scheduler: issues one-block core jobs, double-buffers blocks, drains 32-bit words.
// Optional core_done watchdog enabled by defining CHACHA_SCHED_WDOG_EN.
module chacha20_keystream_sched #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_load,
   input  logic [255:0]                cfg_key,
   input  logic [95:0]                 cfg_nonce,
   input  logic [31:0]                 cfg_counter,
   output logic                        core_start,
   output logic [255:0]                core_key,
   output logic [95:0]                 core_nonce,
   output logic [31:0]                 core_counter,
   output logic [1:0]                  core_parallel,
   input  logic [511:0]                core_ks,
   input  logic                        core_done,
   chacha20_keystream_sched_if.master  ks,
   output logic                        busy,
   output logic                        exhausted,
   output logic                        err_timeout
);
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned BLOCK_W  = 512;
   localparam int unsigned WORDS    = 16;
   localparam int unsigned WIDX_W   = 4;
   localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS - 1);
   localparam logic [31:0]       CTR_MAX   = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DISCARD} state_t;

   state_t                       state_q, state_d;
   logic                         configured_q;
   logic                         err_q;
   logic [31:0]                  ctr_q;
   logic [BLOCK_W-1:0]           slot_q [2];
   logic                         head_q, head_d, tail_q;
   logic [1:0]                   count_q, count_d;
   logic [WIDX_W-1:0]            widx_q, widx_d;
   logic                         hs, pop, push, timeout;
   logic [WORDS-1:0][WORD_W-1:0] head_blk;

   assign core_parallel = 2'b00;

   // Buffer bookkeeping; a block captured this cycle may already be the next head.
   always_comb begin
      hs      = ks.ks_valid & ks.ks_ready & ~cfg_load;
      pop     = hs & (widx_q == WIDX_LAST);
      push    = (state_q == WAIT) & core_done & ~cfg_load & ~timeout;
      head_d  = head_q;
      count_d = count_q;
      widx_d  = widx_q;
      if (cfg_load) begin
         head_d  = 1'b0;
         count_d = 2'd0;
         widx_d  = '0;
      end else begin
         head_d  = head_q ^ pop;
         count_d = count_q + 2'(push) - 2'(pop);
         if (hs) widx_d = widx_q + WIDX_W'(1);
      end
      head_blk = (push && (tail_q == head_d)) ? core_ks : slot_q[head_d];
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!cfg_load && configured_q && !exhausted && !err_q && count_d != 2'd2)
                     state_d = ISSUE;
         ISSUE:   state_d = cfg_load ? DISCARD : WAIT;
         WAIT:    if (timeout || core_done) state_d = IDLE;
                  else if (cfg_load)        state_d = DISCARD;
         DISCARD: if (timeout || core_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         configured_q <= 1'b0;
         ctr_q        <= '0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         count_q      <= 2'd0;
         widx_q       <= '0;
         core_start   <= 1'b0;
         core_key     <= '0;
         core_nonce   <= '0;
         core_counter <= '0;
         busy         <= 1'b0;
         exhausted    <= 1'b0;
         ks.ks_valid  <= 1'b0;
         ks.ks_word   <= '0;
         ks.ks_last   <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         count_q     <= count_d;
         widx_q      <= widx_d;
         core_start  <= (state_d == ISSUE);
         busy        <= (state_d != IDLE);
         ks.ks_valid <= (count_d != 2'd0);
         ks.ks_word  <= (count_d != 2'd0) ? head_blk[widx_d] : '0;
         ks.ks_last  <= (count_d != 2'd0) && (widx_d == WIDX_LAST);
         if (state_d == ISSUE) core_counter <= ctr_q;
         if (cfg_load)  tail_q <= 1'b0;
         else if (push) tail_q <= ~tail_q;
         if (cfg_load) begin
            core_key     <= cfg_key;
            core_nonce   <= cfg_nonce;
            ctr_q        <= cfg_counter;
            configured_q <= 1'b1;
            exhausted    <= 1'b0;
         end else begin
            if (push) ctr_q <= ctr_q + 32'd1;
            if (state_d == ISSUE && ctr_q == CTR_MAX) exhausted <= 1'b1;
         end
      end
   end

   // Block payload storage needs no reset: a slot is only read once it holds a captured block.
   always_ff @(posedge clk) begin
      if (push) slot_q[tail_q] <= core_ks;
   end

`ifdef CHACHA_SCHED_WDOG_EN
   localparam int unsigned       WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0]              wd_cnt_q;

   // Counts cycles since core_start; the start cycle itself is cycle 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_q == ISSUE)
            wd_cnt_q <= WD_W'(1);
         else if ((state_q == WAIT || state_q == DISCARD) && !timeout)
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
         if (cfg_load)     err_q <= 1'b0;
         else if (timeout) err_q <= 1'b1;
      end
   end

   assign timeout     = (state_q == WAIT || state_q == DISCARD) && (wd_cnt_q >= WD_LAST);
   assign err_timeout = err_q;
`else
   logic unused_wdog_cfg;
   assign unused_wdog_cfg = ^TIMEOUT_CYCLES;
   assign timeout         = 1'b0;
   assign err_q           = 1'b0;
   assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_chacha20_keystream_sched.sv
// Bench for chacha20_keystream_sched: stub core, stream model and directed scenarios.
module tb_chacha20_keystream_sched;
`ifdef CHACHA_SCHED_WDOG_EN
   localparam int unsigned TB_TIMEOUT = 16;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         cfg_load;
   logic [255:0] cfg_key;
   logic [95:0]  cfg_nonce;
   logic [31:0]  cfg_counter;
   logic         core_start;
   logic [255:0] core_key;
   logic [95:0]  core_nonce;
   logic [31:0]  core_counter;
   logic [1:0]   core_parallel;
   logic [511:0] core_ks;
   logic         core_done;
   logic         busy, exhausted, err_timeout;
   logic         stub_en;
   logic [2:0]   stub_cnt;
   logic [31:0]  stub_ctr;
   int           cyc = 0;

   chacha20_keystream_sched_if ks_if ();

   chacha20_keystream_sched #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
      .cfg_counter(cfg_counter), .core_start(core_start), .core_key(core_key),
      .core_nonce(core_nonce), .core_counter(core_counter), .core_parallel(core_parallel),
      .core_ks(core_ks), .core_done(core_done), .ks(ks_if.master), .busy(busy),
      .exhausted(exhausted), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [511:0] stub_block(input logic [31:0] c);
      logic [511:0] b;
      for (int w = 0; w < 16; w++) b[32*w +: 32] = {c[23:0], 8'(w)};
      return b;
   endfunction

   // Stub core: done pulse exactly 6 cycles after the start pulse.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         stub_cnt  <= 3'd0;
         stub_ctr  <= 32'd0;
         core_done <= 1'b0;
         core_ks   <= '0;
      end else begin
         core_done <= 1'b0;
         if (stub_cnt != 3'd0) begin
            stub_cnt <= stub_cnt - 3'd1;
            if (stub_cnt == 3'd1 && stub_en) begin
               core_done <= 1'b1;
               core_ks   <= stub_block(stub_ctr);
            end
         end
         if (core_start) begin
            stub_cnt <= 3'd5;
            stub_ctr <= core_counter;
         end
      end
   end

   int          checks = 0;
   int          errors = 0;
   int          n_starts, got_n, n_last;
   int          start_cyc [8];
   logic [31:0] start_ctr [8];
   logic [31:0] got_words [64];
   int          last15_cyc [4];
   int          first_valid_cyc, first_done_cyc, err_rise_cyc, load_cyc;
   logic        held, err_prev;
   logic [31:0] held_word;
   logic [31:0] m_ctr;
   int          m_w;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_records();
      n_starts = 0; got_n = 0; n_last = 0;
      first_valid_cyc = -1; first_done_cyc = -1; err_rise_cyc = -1;
   endtask

   task automatic do_load(input logic [31:0] ctr);
      @(posedge clk); #1;
      cfg_counter = ctr;
      cfg_load    = 1'b1;
      load_cyc    = cyc;
      clear_records();
      @(posedge clk); #1;
      cfg_load = 1'b0;
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k = 0;
      while (n_starts < n && k < budget) begin @(negedge clk); k++; end
      check("wait_starts_in_budget", 64'(n_starts >= n), 64'd1);
   endtask

   task automatic wait_words(input int n, input int budget);
      int k = 0;
      while (got_n < n && k < budget) begin @(negedge clk); k++; end
      check("wait_words_in_budget", 64'(got_n >= n), 64'd1);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!ks_if.ks_valid && k < budget) begin @(negedge clk); k++; end
      check("wait_valid_in_budget", 64'(ks_if.ks_valid), 64'd1);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_start", 64'(core_start), 64'd0);
      check("rst_valid", 64'(ks_if.ks_valid), 64'd0);
      check("rst_word", 64'(ks_if.ks_word), 64'd0);
      check("rst_ctr", 64'(core_counter), 64'd0);
      check_wide("rst_key", core_key, 256'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_records();
   endtask

   initial begin
      #2000000;
      $display("FAIL global_time_limit: got no end, required finish");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; cfg_load = 1'b0; ks_if.ks_ready = 1'b0; stub_en = 1'b1;
      cfg_key   = 256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f;
      cfg_nonce = 96'h000000090000004a00000000;
      cfg_counter = 32'd0;
      held = 1'b0; err_prev = 1'b0; m_ctr = 32'd0; m_w = 0; load_cyc = 0;
      clear_records();
      fork
         // Stream model: expected words derive from the load counter and block order.
         forever begin
            @(negedge clk);
            if (rst) begin
               held = 1'b0; err_prev = 1'b0;
            end else begin
               if (held) begin
                  check("hold_valid", 64'(ks_if.ks_valid), 64'd1);
                  check("hold_word", 64'(ks_if.ks_word), 64'(held_word));
               end
               held      = ks_if.ks_valid && !ks_if.ks_ready && !cfg_load;
               held_word = ks_if.ks_word;
               if (core_start && n_starts < 8) begin
                  start_cyc[n_starts] = cyc;
                  start_ctr[n_starts] = core_counter;
               end
               if (core_start) n_starts++;
               if (core_done && first_done_cyc < 0) first_done_cyc = cyc;
               if (ks_if.ks_valid && !cfg_load && first_valid_cyc < 0) first_valid_cyc = cyc;
               if (err_timeout && !err_prev) err_rise_cyc = cyc;
               err_prev = err_timeout;
               if (cfg_load) begin
                  m_ctr = cfg_counter;
                  m_w   = 0;
               end else if (ks_if.ks_valid && ks_if.ks_ready) begin
                  check("stream_word", 64'(ks_if.ks_word), 64'({m_ctr[23:0], 8'(m_w)}));
                  check("stream_last", 64'(ks_if.ks_last), 64'(m_w == 15));
                  if (got_n < 64) got_words[got_n] = ks_if.ks_word;
                  got_n++;
                  if (ks_if.ks_last && n_last < 4) last15_cyc[n_last] = cyc;
                  if (ks_if.ks_last) n_last++;
                  if (m_w == 15) begin m_w = 0; m_ctr = m_ctr + 32'd1; end
                  else m_w++;
               end
            end
         end
         begin
            repeat (3) @(posedge clk); #1;
            check("reset_valid", 64'(ks_if.ks_valid), 64'd0);
            check("reset_start", 64'(core_start), 64'd0);
            check("reset_busy", 64'(busy), 64'd0);
            check("reset_exhausted", 64'(exhausted), 64'd0);
            check("reset_err_timeout", 64'(err_timeout), 64'd0);
            check_wide("reset_key", core_key, 256'd0);
            rst = 1'b0;
            repeat (5) @(negedge clk);
            check("no_start_unconfigured", 64'(n_starts), 64'd0);

            // Free-running stream from counter 1.
            ks_if.ks_ready = 1'b1;
            do_load(32'd1);
            wait_words(32, 200);
            check("first_start_latency", 64'(start_cyc[0]), 64'(load_cyc + 2));
            check("first_valid_latency", 64'(first_valid_cyc), 64'(first_done_cyc + 1));
            check_wide("core_key", core_key, cfg_key);
            check_wide("core_nonce", 256'(core_nonce), 256'(cfg_nonce));
            check("core_parallel", 64'(core_parallel), 64'd0);
            check("t1_word0", 64'(got_words[0]), 64'h0000_0100);
            check("t1_word15", 64'(got_words[15]), 64'h0000_010F);
            check("t1_word16", 64'(got_words[16]), 64'h0000_0200);
            check("t1_word31", 64'(got_words[31]), 64'h0000_020F);

            // Backpressure: two prefetched blocks, then refill right after slot free.
            ks_if.ks_ready = 1'b0;
            do_load(32'd1);
            repeat (40) @(negedge clk);
            check("bp_two_starts", 64'(n_starts), 64'd2);
            check("bp_ctr0", 64'(start_ctr[0]), 64'd1);
            check("bp_ctr1", 64'(start_ctr[1]), 64'd2);
            @(posedge clk); #1;
            ks_if.ks_ready = 1'b1;
            begin
               int k = 0;
               while (n_last < 1 && k < 60) begin @(negedge clk); k++; end
            end
            check("bp_block_done", 64'(n_last >= 1), 64'd1);
            repeat (3) @(negedge clk);
            check("bp_third_start_count", 64'(n_starts), 64'd3);
            check("bp_third_start_cycle", 64'(start_cyc[2]), 64'(last15_cyc[0] + 1));
            check("bp_ctr2", 64'(start_ctr[2]), 64'd3);

            // Counter wrap: blocks FE and FF, then exhausted.
            do_load(32'hFFFF_FFFE);
            wait_words(32, 200);
            repeat (20) @(negedge clk);
            check("ex_starts", 64'(n_starts), 64'd2);
            check("ex_ctr1", 64'(start_ctr[1]), 64'hFFFF_FFFF);
            check("ex_flag", 64'(exhausted), 64'd1);
            check("ex_words", 64'(got_n), 64'd32);
            check("ex_word0", 64'(got_words[0]), 64'hFFFF_FE00);
            check("ex_word31", 64'(got_words[31]), 64'hFFFF_FF0F);
            check("ex_idle_valid", 64'(ks_if.ks_valid), 64'd0);
            do_load(32'd1);
            check("ex_cleared", 64'(exhausted), 64'd0);

            // Reload while a job is in flight: stale block dropped.
            do_load(32'd5);
            wait_starts(1, 20);
            repeat (2) @(posedge clk);
            do_load(32'h40);
            wait_words(16, 100);
            check("rl_start_ctr", 64'(start_ctr[0]), 64'h40);
            check("rl_word0", 64'(got_words[0]), 64'h0000_4000);
            check("rl_word15", 64'(got_words[15]), 64'h0000_400F);

            // Asynchronous reset mid-WAIT, then mid-drain.
            do_load(32'd7);
            wait_starts(1, 20);
            pulse_reset();
            repeat (20) @(negedge clk);
            check("rst_wait_no_start", 64'(n_starts), 64'd0);
            ks_if.ks_ready = 1'b0;
            do_load(32'd9);
            wait_valid(30);
            pulse_reset();
            repeat (20) @(negedge clk);
            check("rst_drain_no_start", 64'(n_starts), 64'd0);
            check("rst_drain_valid", 64'(ks_if.ks_valid), 64'd0);

            // Core that never completes.
            stub_en = 1'b0;
            ks_if.ks_ready = 1'b1;
            do_load(32'd3);
            wait_starts(1, 20);
`ifdef CHACHA_SCHED_WDOG_EN
            repeat (24) @(negedge clk);
            check("wd_err", 64'(err_timeout), 64'd1);
            check("wd_err_cycle", 64'(err_rise_cyc), 64'(start_cyc[0] + 16));
            check("wd_busy", 64'(busy), 64'd0);
            check("wd_no_restart", 64'(n_starts), 64'd1);
            stub_en = 1'b1;
            do_load(32'd3);
            check("wd_cleared", 64'(err_timeout), 64'd0);
            wait_words(16, 100);
            check("wd_recover_word0", 64'(got_words[0]), 64'h0000_0300);
`else
            repeat (40) @(negedge clk);
            check("nowd_err", 64'(err_timeout), 64'd0);
            check("nowd_busy", 64'(busy), 64'd1);
            check("nowd_no_restart", 64'(n_starts), 64'd1);
`endif
         end
      join_any
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
